// File: rtl/tdp_ram_array_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdp_ram_array_pkg
// Brief    : Shared state encoding and read-during-write constants for the
//            true dual-port RAM array.
// Revision : 1.0 - initial release
// ============================================================================
package tdp_ram_array_pkg;

    // Clear-engine state: RUN serves the ports, CLEAR zero-fills the array.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Same-port read-during-write behaviour.
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

endpackage : tdp_ram_array_pkg
`default_nettype wire

// File: rtl/tdp_ram_outpipe.sv
`default_nettype none
// ============================================================================
// Module   : tdp_ram_outpipe
// Brief    : Optional output register stage and valid strobe for one RAM
//            port. The data register only loads on a valid beat, so the
//            output holds its last value between accesses.
// Revision : 1.0 - initial release
// ============================================================================
module tdp_ram_outpipe
    import tdp_ram_array_pkg::*;
#(
    parameter int DATA_W  = 72,
    parameter int OUT_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    generate
        if (OUT_REG != 0) begin : g_reg
            logic              valid_q;
            logic [DATA_W-1:0] data_q;

            // Extra pipeline stage; data captured only on a valid beat.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_i;
                    if (valid_i) begin
                        data_q <= data_i;
                    end
                end
            end

            assign valid_o = valid_q;
            assign data_o  = data_q;
        end else begin : g_bypass
            // Clock and reset are only needed by the registered variant.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            assign valid_o = valid_i;
            assign data_o  = data_i;
        end
    endgenerate

endmodule : tdp_ram_outpipe
`default_nettype wire

// File: rtl/tdp_ram_array.sv
`default_nettype none
// ============================================================================
// Module   : tdp_ram_array
// Brief    : Single-clock true dual-port RAM with configurable read latency,
//            same-port read-during-write mode, write-write collision flag
//            and a sequential zero-fill clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module tdp_ram_array
    import tdp_ram_array_pkg::*;
#(
    parameter int DATA_W     = 72,
    parameter int ADDR_W     = 10,
    parameter int OUT_REG    = 1,
    parameter int RDW_MODE   = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta,
    output logic              valida,
    input  logic              enb,
    input  logic              web,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dinb,
    output logic [DATA_W-1:0] doutb,
    output logic              validb,
    output logic              coll
);

    localparam int               DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam state_e           RST_STATE  = (CLR_ON_RST != 0) ? CLEAR : RUN;
    localparam bit               WR_FIRST   = (RDW_MODE == RDW_WRITE_FIRST);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    // Plain storage array, no reset, so it maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rd_a_q, rd_b_q;
    logic              rv_a_q, rv_b_q;
    logic              coll_q;

    logic acc_a, acc_b, wr_a, wr_b, same_addr;

    assign busy      = (state_q == CLEAR);
    assign acc_a     = ena & ~busy;
    assign acc_b     = enb & ~busy;
    assign wr_a      = acc_a & wea;
    assign wr_b      = acc_b & web;
    assign same_addr = (addra == addrb);

    // Clear-engine state and address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state: enter CLEAR on request, walk every address once, return.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            RUN: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + ONE_ADDR;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d   = RUN;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Array writes: clear engine owns the array while busy; on a same-address
    // double write port A is the one that lands.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            if (wr_b && !(wr_a && same_addr)) begin
                mem[addrb] <= dinb;
            end
            if (wr_a) begin
                mem[addra] <= dina;
            end
        end
    end

    // Port A read stage; cross-port writes are not visible (old data).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_a_q <= '0;
            rv_a_q <= 1'b0;
        end else begin
            rv_a_q <= acc_a;
            if (acc_a) begin
                rd_a_q <= (WR_FIRST && wea) ? dina : mem[addra];
            end
        end
    end

    // Port B read stage, mirror of port A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_b_q <= '0;
            rv_b_q <= 1'b0;
        end else begin
            rv_b_q <= acc_b;
            if (acc_b) begin
                rd_b_q <= (WR_FIRST && web) ? dinb : mem[addrb];
            end
        end
    end

    // One-cycle flag for two writes to the same address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= wr_a & wr_b & same_addr;
        end
    end

    assign coll = coll_q;

    tdp_ram_outpipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_pipe_a (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rv_a_q),
        .data_i  (rd_a_q),
        .valid_o (valida),
        .data_o  (douta)
    );

    tdp_ram_outpipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_pipe_b (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rv_b_q),
        .data_i  (rd_b_q),
        .valid_o (validb),
        .data_o  (doutb)
    );

endmodule : tdp_ram_array
`default_nettype wire

// File: tb/tb_tdp_ram_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdp_ram_array
// Brief    : Directed self-checking bench for tdp_ram_array (ADDR_W=4,
//            OUT_REG=1, read-first, clear on reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdp_ram_array;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic              clr_req;
    logic              busy;
    logic              ena, wea, enb, web;
    logic [ADDR_W-1:0] addra, addrb;
    logic [DATA_W-1:0] dina, dinb, douta, doutb;
    logic              valida, validb, coll;

    int n_total = 0;
    int n_bad   = 0;

    tdp_ram_array #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .OUT_REG    (1),
        .RDW_MODE   (0),
        .CLR_ON_RST (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .ena     (ena),
        .wea     (wea),
        .addra   (addra),
        .dina    (dina),
        .douta   (douta),
        .valida  (valida),
        .enb     (enb),
        .web     (web),
        .addrb   (addrb),
        .dinb    (dinb),
        .doutb   (doutb),
        .validb  (validb),
        .coll    (coll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        enb = 1'b0; web = 1'b0; addrb = '0; dinb = '0;
    endtask

    task automatic write_a(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ena = 1'b1; wea = 1'b1; addra = a; dina = d;
        tick();
        idle();
    endtask

    task automatic read_a(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string tag);
        ena = 1'b1; wea = 1'b0; addra = a;
        tick();
        idle();
        tick();
        check_eq({tag, "_va"}, {31'd0, valida}, 32'd1);
        check_eq(tag, {16'd0, douta}, {16'd0, exp});
    endtask

    task automatic read_b(input logic [ADDR_W-1:0] b, input logic [DATA_W-1:0] exp, input string tag);
        enb = 1'b1; web = 1'b0; addrb = b;
        tick();
        idle();
        tick();
        check_eq({tag, "_vb"}, {31'd0, validb}, 32'd1);
        check_eq(tag, {16'd0, doutb}, {16'd0, exp});
    endtask

    // Count cycles until busy drops, bounded.
    task automatic wait_clear(input int exp, input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check_eq(tag, n, exp);
    endtask

    initial begin
        int  n;
        logic quiet_ok;

        rst = 1'b1; clr_req = 1'b0; idle();
        #1;
        // Reset state
        check_eq("rst_busy",   {31'd0, busy},   32'd1);
        check_eq("rst_douta",  {16'd0, douta},  32'd0);
        check_eq("rst_doutb",  {16'd0, doutb},  32'd0);
        check_eq("rst_valida", {31'd0, valida}, 32'd0);
        check_eq("rst_validb", {31'd0, validb}, 32'd0);
        check_eq("rst_coll",   {31'd0, coll},   32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Power-on clear: 16 cycles, then every word reads 0
        wait_clear(16, "init_clear_len");
        for (int i = 0; i < 16; i++) begin
            read_a(i[ADDR_W-1:0], 16'h0000, "init_zero");
        end
        read_b(4'd15, 16'h0000, "init_zero_b");

        // A writes 0x0AB @5, B reads @5 next cycle; validb 2 cycles after read
        ena = 1'b1; wea = 1'b1; addra = 4'd5; dina = 16'h00AB;
        tick();
        idle();
        enb = 1'b1; addrb = 4'd5;
        tick();
        idle();
        check_eq("wr5_valida",   {31'd0, valida}, 32'd1);
        check_eq("wr5_douta_old", {16'd0, douta}, 32'd0);
        check_eq("rd5_validb_e1", {31'd0, validb}, 32'd0);
        tick();
        check_eq("rd5_validb_e2", {31'd0, validb}, 32'd1);
        check_eq("rd5_doutb",     {16'd0, doutb},  32'h00AB);
        check_eq("wr5_valida_off", {31'd0, valida}, 32'd0);
        tick();
        check_eq("rd5_validb_off", {31'd0, validb}, 32'd0);
        check_eq("rd5_doutb_hold", {16'd0, doutb},  32'h00AB);

        // Write-write collision at addr 3: A wins, coll pulses once
        ena = 1'b1; wea = 1'b1; addra = 4'd3; dina = 16'h0011;
        enb = 1'b1; web = 1'b1; addrb = 4'd3; dinb = 16'h0022;
        tick();
        idle();
        check_eq("coll_pulse", {31'd0, coll}, 32'd1);
        tick();
        check_eq("coll_off", {31'd0, coll}, 32'd0);
        read_a(4'd3, 16'h0011, "coll_winner");

        // Read-during-write: cross port sees old data, same port read-first
        write_a(4'd7, 16'h0055);
        tick();
        ena = 1'b1; wea = 1'b1; addra = 4'd7; dina = 16'h0066;
        enb = 1'b1; web = 1'b0; addrb = 4'd7;
        tick();
        idle();
        tick();
        check_eq("rdw_cross_b", {16'd0, doutb}, 32'h0055);
        check_eq("rdw_same_a",  {16'd0, douta}, 32'h0055);
        check_eq("rdw_nocoll",  {31'd0, coll},  32'd0);
        ena = 1'b1; wea = 1'b1; addra = 4'd7; dina = 16'h0077;
        tick();
        idle();
        tick();
        check_eq("rdw_same_a2", {16'd0, douta}, 32'h0066);
        read_b(4'd7, 16'h0077, "rdw_final");

        // Clear sequence with in-flight read, ignored writes, repeated
        // request and reset at clr_cnt=8
        write_a(4'd2, 16'h0099);
        write_a(4'd9, 16'h009A);
        tick();
        clr_req = 1'b1; enb = 1'b1; addrb = 4'd9;
        tick();
        clr_req = 1'b0; idle();
        check_eq("clr_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("inflight_vb", {31'd0, validb}, 32'd1);
        check_eq("inflight_db", {16'd0, doutb},  32'h009A);
        quiet_ok = 1'b1;
        for (int k = 1; k < 8; k++) begin
            clr_req = (k == 2);
            ena = 1'b1; wea = 1'b1; addra = 4'd12; dina = 16'hBEEF;
            enb = 1'b1; web = 1'b1; addrb = 4'd12; dinb = 16'hCAFE;
            tick();
            if (valida || validb || coll || !busy) quiet_ok = 1'b0;
        end
        check_eq("clr1_quiet", {31'd0, quiet_ok}, 32'd1);
        clr_req = 1'b0; idle();
        rst = 1'b1;
        #1;
        check_eq("rst2_busy",  {31'd0, busy},  32'd1);
        check_eq("rst2_doutb", {16'd0, doutb}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        n = 0;
        quiet_ok = 1'b1;
        while (busy && n < 100) begin
            if (n == 5) begin
                clr_req = 1'b1;
                ena = 1'b1; wea = 1'b1; addra = 4'd0; dina = 16'h1234;
                enb = 1'b1; web = 1'b1; addrb = 4'd0; dinb = 16'h5678;
            end
            if (n == 7) begin
                clr_req = 1'b0;
                idle();
            end
            tick();
            n++;
            if (valida || validb || coll) quiet_ok = 1'b0;
        end
        clr_req = 1'b0; idle();
        check_eq("clr2_len",   n, 32'd16);
        check_eq("clr2_quiet", {31'd0, quiet_ok}, 32'd1);
        read_a(4'd0,  16'h0000, "post_clr_0");
        read_a(4'd2,  16'h0000, "post_clr_2");
        read_a(4'd9,  16'h0000, "post_clr_9");
        read_b(4'd12, 16'h0000, "post_clr_12");
        read_b(4'd15, 16'h0000, "post_clr_15");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_tdp_ram_array
`default_nettype wire
